// File: rtl/lpif_rxtx_x16_asym1_full_slave_gearbox.sv
//------------------------------------------------------------------------------
// lpif_rxtx_x16_asym1_full_slave_gearbox
//
// Gearbox between a full-rate LPIF beat interface and a half-rate link word
// interface. Each link word carries two LPIF beats of 537 bits:
//   lower beat in [536:0], upper beat in [1073:537].
// Beat layout (LSB first): state[3:0], protid[1:0], data[511:0], dvalid,
//   crc[15:0], crc_valid, valid.
//
// RX path: link words are buffered in a small FIFO (RX_DEPTH entries). Each
//   buffered word is emitted as two consecutive registered dstrm_* beats,
//   first the lower half and then the upper half. The head is popped when the
//   upper half is emitted. When nothing is buffered, dstrm_* read as zero.
// TX path: valid ustrm_* beats are gathered in pairs. The first beat is held,
//   and the second beat is combined with it into one registered link word.
//   If the output word is still waiting for the link when a pair completes,
//   that pair is dropped and the sticky tx_overflow flag is set.
//
// Ports
//   clk_wr, rst_wr_n           : clock; asynchronous active-low reset
//   rxfifo_downstream_*        : link word in (valid/ready handshake)
//   dstrm_*                    : unpacked full-rate downstream beat out
//   ustrm_*                    : full-rate upstream beat in
//   txfifo_upstream_*          : packed link word out (valid/ready handshake)
//   tx_overflow                : sticky, an upstream pair was dropped
//
// All outputs except rxfifo_downstream_ready come straight from registers.
// rxfifo_downstream_ready depends only on FIFO state and never on
// rxfifo_downstream_valid.
//------------------------------------------------------------------------------
module lpif_rxtx_x16_asym1_full_slave_gearbox #(
    parameter int RX_DEPTH = 2
) (
    input  logic          clk_wr,
    input  logic          rst_wr_n,

    input  logic [1073:0] rxfifo_downstream_data,
    input  logic          rxfifo_downstream_valid,
    output logic          rxfifo_downstream_ready,

    output logic [3:0]    dstrm_state,
    output logic [1:0]    dstrm_protid,
    output logic [511:0]  dstrm_data,
    output logic          dstrm_dvalid,
    output logic [15:0]   dstrm_crc,
    output logic          dstrm_crc_valid,
    output logic          dstrm_valid,

    input  logic [3:0]    ustrm_state,
    input  logic [1:0]    ustrm_protid,
    input  logic [511:0]  ustrm_data,
    input  logic          ustrm_dvalid,
    input  logic [15:0]   ustrm_crc,
    input  logic          ustrm_crc_valid,
    input  logic          ustrm_valid,

    output logic [1073:0] txfifo_upstream_data,
    output logic          txfifo_upstream_valid,
    input  logic          txfifo_upstream_ready,

    output logic          tx_overflow
);

    localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(RX_DEPTH);

    // One LPIF beat; packed MSB first, so state lands at bit 0.
    typedef struct packed {
        logic        valid;
        logic        crc_valid;
        logic [15:0] crc;
        logic        dvalid;
        logic [511:0] data;
        logic [1:0]  protid;
        logic [3:0]  state;
    } beat_t;

    // Which half of a link word is being handled next.
    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_e;

    //--------------------------------------------------------------------------
    // RX path
    //--------------------------------------------------------------------------
    logic [1073:0] rx_mem [RX_DEPTH];
    logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    phase_e        rx_ph_q, rx_ph_d;
    beat_t         dstrm_q, dstrm_d;
    logic [1073:0] rx_head;
    logic          rx_push;
    logic          rx_pop;
    logic          rx_nonempty;

    assign rx_nonempty = (rx_cnt_q != '0);
    assign rx_head     = rx_mem[rx_rd_ptr_q];

    // The head is popped in the cycle its upper half is emitted, so a full
    // FIFO can still accept a word in that same cycle.
    assign rx_pop                  = rx_nonempty && (rx_ph_q == PH_HI);
    assign rxfifo_downstream_ready = (rx_cnt_q != FULL_CNT) || rx_pop;
    assign rx_push                 = rxfifo_downstream_valid && rxfifo_downstream_ready;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        rx_ph_d     = rx_ph_q;
        dstrm_d     = '0;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_cnt_d    = rx_cnt_q;

        if (rx_nonempty) begin
            if (rx_ph_q == PH_LO) begin
                dstrm_d = beat_t'(rx_head[536:0]);
                rx_ph_d = PH_HI;
            end else begin
                dstrm_d = beat_t'(rx_head[1073:537]);
                rx_ph_d = PH_LO;
            end
        end

        // Power-of-two depth: pointers wrap by natural overflow.
        if (rx_push) begin
            rx_wr_ptr_d = rx_wr_ptr_q + AW'(1);
        end
        if (rx_pop) begin
            rx_rd_ptr_d = rx_rd_ptr_q + AW'(1);
        end

        unique case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    // NOTE: the storage array has no reset; emptiness is defined by the
    // pointers and counter, so stale contents are never observed.
    always_ff @(posedge clk_wr) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr_q] <= rxfifo_downstream_data;
        end
    end

    assign dstrm_state     = dstrm_q.state;
    assign dstrm_protid    = dstrm_q.protid;
    assign dstrm_data      = dstrm_q.data;
    assign dstrm_dvalid    = dstrm_q.dvalid;
    assign dstrm_crc       = dstrm_q.crc;
    assign dstrm_crc_valid = dstrm_q.crc_valid;
    assign dstrm_valid     = dstrm_q.valid;

    //--------------------------------------------------------------------------
    // TX path
    //--------------------------------------------------------------------------
    beat_t         ustrm_beat;
    phase_e        tx_ph_q, tx_ph_d;
    beat_t         tx_lo_q, tx_lo_d;
    logic [1073:0] tx_word_q, tx_word_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_ovf_q, tx_ovf_d;
    logic          tx_drain;
    logic          tx_blocked;

    assign ustrm_beat = {ustrm_valid, ustrm_crc_valid, ustrm_crc, ustrm_dvalid,
                         ustrm_data, ustrm_protid, ustrm_state};

    assign tx_drain   = tx_valid_q && txfifo_upstream_ready;
    assign tx_blocked = tx_valid_q && !txfifo_upstream_ready;

    always_comb begin
        tx_ph_d    = tx_ph_q;
        tx_lo_d    = tx_lo_q;
        tx_word_d  = tx_word_q;
        tx_valid_d = tx_valid_q;
        tx_ovf_d   = tx_ovf_q;

        if (tx_drain) begin
            tx_valid_d = 1'b0;
            tx_word_d  = '0;
        end

        // Beats with valid low are not part of the stream at all.
        if (ustrm_valid) begin
            if (tx_ph_q == PH_LO) begin
                tx_lo_d = ustrm_beat;
                tx_ph_d = PH_HI;
            end else begin
                tx_ph_d = PH_LO;
                if (tx_blocked) begin
                    // Output still occupied: the whole pair is lost, the held
                    // word is left untouched.
                    tx_ovf_d = 1'b1;
                end else begin
                    tx_word_d  = {ustrm_beat, tx_lo_q};
                    tx_valid_d = 1'b1;
                end
            end
        end
    end

    assign txfifo_upstream_data  = tx_word_q;
    assign txfifo_upstream_valid = tx_valid_q;
    assign tx_overflow           = tx_ovf_q;

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            rx_ph_q     <= PH_LO;
            dstrm_q     <= '0;
            tx_ph_q     <= PH_LO;
            tx_lo_q     <= '0;
            tx_word_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_ovf_q    <= 1'b0;
        end else begin
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_ph_q     <= rx_ph_d;
            dstrm_q     <= dstrm_d;
            tx_ph_q     <= tx_ph_d;
            tx_lo_q     <= tx_lo_d;
            tx_word_q   <= tx_word_d;
            tx_valid_q  <= tx_valid_d;
            tx_ovf_q    <= tx_ovf_d;
        end
    end

endmodule

// File: tb/tb_lpif_rxtx_x16_asym1_full_slave_gearbox.sv
//------------------------------------------------------------------------------
// Testbench for lpif_rxtx_x16_asym1_full_slave_gearbox.
// A behavioural reference model (queue of buffered link words plus a half
// selector for RX, a pair-gathering model for TX) predicts every output one
// clock ahead. Inputs change 1 time unit after the rising edge; outputs are
// sampled at that same point, away from the active edge.
//------------------------------------------------------------------------------
module tb_lpif_rxtx_x16_asym1_full_slave_gearbox;

    localparam int DEPTH = 2;

    logic          clk_wr = 1'b0;
    logic          rst_wr_n;
    logic [1073:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [3:0]    d_state;
    logic [1:0]    d_protid;
    logic [511:0]  d_data;
    logic          d_dvalid;
    logic [15:0]   d_crc;
    logic          d_crc_valid;
    logic          d_valid;
    logic [536:0]  u_beat;
    logic [1073:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_ovf;

    always #5 clk_wr = ~clk_wr;

    lpif_rxtx_x16_asym1_full_slave_gearbox #(.RX_DEPTH(DEPTH)) dut (
        .clk_wr                  (clk_wr),
        .rst_wr_n                (rst_wr_n),
        .rxfifo_downstream_data  (rx_data),
        .rxfifo_downstream_valid (rx_valid),
        .rxfifo_downstream_ready (rx_ready),
        .dstrm_state             (d_state),
        .dstrm_protid            (d_protid),
        .dstrm_data              (d_data),
        .dstrm_dvalid            (d_dvalid),
        .dstrm_crc               (d_crc),
        .dstrm_crc_valid         (d_crc_valid),
        .dstrm_valid             (d_valid),
        .ustrm_state             (u_beat[3:0]),
        .ustrm_protid            (u_beat[5:4]),
        .ustrm_data              (u_beat[517:6]),
        .ustrm_dvalid            (u_beat[518]),
        .ustrm_crc               (u_beat[534:519]),
        .ustrm_crc_valid         (u_beat[535]),
        .ustrm_valid             (u_beat[536]),
        .txfifo_upstream_data    (tx_data),
        .txfifo_upstream_valid   (tx_valid),
        .txfifo_upstream_ready   (tx_ready),
        .tx_overflow             (tx_ovf)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [1073:0] m_q[$];
    bit            m_half;
    logic [536:0]  m_dstrm;
    bit            m_have_lo;
    logic [536:0]  m_lo;
    logic [1073:0] m_word;
    bit            m_valid;
    bit            m_ovf;

    // Observations gathered while stepping
    bit            last_accept;
    int            tx_pulses;
    logic [1073:0] last_tx_word;

    function automatic logic [536:0] rand_beat(input bit v);
        logic [536:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        b[536:512] = 25'($urandom);
        b[536] = v;
        return b;
    endfunction

    function automatic logic [536:0] dstrm_now();
        return {d_valid, d_crc_valid, d_crc, d_dvalid, d_data, d_protid, d_state};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_half    = 0;
        m_dstrm   = '0;
        m_have_lo = 0;
        m_lo      = '0;
        m_word    = '0;
        m_valid   = 0;
        m_ovf     = 0;
    endtask

    // Advance one clock: predict from current inputs, clock, compare.
    task automatic tick();
        bit            exp_ready;
        bit            drain;
        bit            blocked;
        logic [1073:0] head;
        logic [536:0]  act;

        exp_ready = (m_q.size() < DEPTH) || (m_q.size() > 0 && m_half);
        n_cmp++;
        if (rx_ready !== exp_ready) begin
            n_err++;
            $display("FAIL rx_ready: got %b expected %b", rx_ready, exp_ready);
        end
        last_accept = rx_valid && exp_ready;

        if (m_q.size() > 0) begin
            head    = m_q[0];
            m_dstrm = m_half ? head[1073:537] : head[536:0];
            if (m_half) void'(m_q.pop_front());
            m_half = !m_half;
        end else begin
            m_dstrm = '0;
        end
        if (last_accept) m_q.push_back(rx_data);

        drain   = m_valid && tx_ready;
        blocked = m_valid && !tx_ready;
        if (drain) begin
            m_valid = 0;
            m_word  = '0;
        end
        if (u_beat[536]) begin
            if (!m_have_lo) begin
                m_lo      = u_beat;
                m_have_lo = 1;
            end else begin
                m_have_lo = 0;
                if (blocked) m_ovf = 1;
                else begin
                    m_word  = {u_beat, m_lo};
                    m_valid = 1;
                end
            end
        end

        @(posedge clk_wr);
        #1;

        act = dstrm_now();
        n_cmp++;
        if (act !== m_dstrm) begin
            n_err++;
            $display("FAIL dstrm_beat: got %h expected %h", act, m_dstrm);
        end
        n_cmp++;
        if (tx_data[536:0] !== m_word[536:0]) begin
            n_err++;
            $display("FAIL tx_data_lo: got %h expected %h", tx_data[536:0], m_word[536:0]);
        end
        n_cmp++;
        if (tx_data[1073:537] !== m_word[1073:537]) begin
            n_err++;
            $display("FAIL tx_data_hi: got %h expected %h", tx_data[1073:537], m_word[1073:537]);
        end
        n_cmp++;
        if (tx_valid !== m_valid) begin
            n_err++;
            $display("FAIL tx_valid: got %b expected %b", tx_valid, m_valid);
        end
        n_cmp++;
        if (tx_ovf !== m_ovf) begin
            n_err++;
            $display("FAIL tx_overflow: got %b expected %b", tx_ovf, m_ovf);
        end
        if (tx_valid === 1'b1) begin
            tx_pulses++;
            last_tx_word = tx_data;
        end
    endtask

    task automatic idle_inputs();
        rx_valid = 0;
        rx_data  = '0;
        u_beat   = '0;
    endtask

    task automatic test_reset();
        rst_wr_n = 0;
        idle_inputs();
        tx_ready = 0;
        model_reset();
        repeat (3) @(posedge clk_wr);
        #1;
        n_cmp++;
        if (dstrm_now() !== '0 || tx_data !== '0 || tx_valid !== 0 || tx_ovf !== 0) begin
            n_err++;
            $display("FAIL reset_outputs: dstrm_valid=%b tx_valid=%b tx_ovf=%b expected all zero",
                     d_valid, tx_valid, tx_ovf);
        end
        rst_wr_n = 1;
        #1;
        n_cmp++;
        if (rx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b expected 1", rx_ready);
        end
        repeat (2) tick();
    endtask

    task automatic test_rx_single();
        logic [536:0] lo, hi;
        lo = rand_beat(1);
        lo[3:0] = 4'h3;
        hi = rand_beat(1);
        hi[3:0] = 4'h5;
        rx_data  = {hi, lo};
        rx_valid = 1;
        tick();
        idle_inputs();
        tick();
        n_cmp++;
        if (d_state !== 4'h3 || d_valid !== 1'b1) begin
            n_err++;
            $display("FAIL single_lower: got state %h valid %b expected 3 1", d_state, d_valid);
        end
        tick();
        n_cmp++;
        if (d_state !== 4'h5 || d_valid !== 1'b1) begin
            n_err++;
            $display("FAIL single_upper: got state %h valid %b expected 5 1", d_state, d_valid);
        end
        tick();
        n_cmp++;
        if (dstrm_now() !== '0) begin
            n_err++;
            $display("FAIL single_idle: got state %h valid %b expected all zero", d_state, d_valid);
        end
    endtask

    task automatic test_rx_stream();
        int sent = 0;
        int first_acc = -1;
        int last_acc = -1;
        int beats = 0;
        rx_data  = {rand_beat(1), rand_beat(1)};
        rx_valid = 1;
        for (int c = 0; c < 60 && sent < 6; c++) begin
            tick();
            if (d_valid === 1'b1) beats++;
            if (last_accept) begin
                if (first_acc < 0) first_acc = c;
                last_acc = c;
                sent++;
                rx_data = {rand_beat(1), rand_beat(1)};
            end
        end
        idle_inputs();
        n_cmp++;
        if (sent != 6) begin
            n_err++;
            $display("FAIL stream_accept_timeout: got %0d words expected 6", sent);
        end
        for (int c = 0; c < 14; c++) begin
            tick();
            if (d_valid === 1'b1) beats++;
        end
        // Two words fill the empty FIFO back-to-back, then one word per pop
        // every second cycle: acceptances at 0,1,2,4,6,8.
        n_cmp++;
        if (last_acc - first_acc != 8) begin
            n_err++;
            $display("FAIL stream_rate: got span %0d expected 8", last_acc - first_acc);
        end
        n_cmp++;
        if (beats != 12) begin
            n_err++;
            $display("FAIL stream_beats: got %0d expected 12", beats);
        end
    endtask

    task automatic test_tx_pair();
        logic [536:0] c_beat, d_beat;
        c_beat    = rand_beat(1);
        d_beat    = rand_beat(1);
        tx_ready  = 1;
        tx_pulses = 0;
        u_beat = c_beat;
        tick();
        for (int i = 0; i < 3; i++) begin
            u_beat = rand_beat(0);
            tick();
        end
        u_beat = d_beat;
        tick();
        u_beat = '0;
        repeat (3) tick();
        n_cmp++;
        if (tx_pulses != 1) begin
            n_err++;
            $display("FAIL pair_pulses: got %0d expected 1", tx_pulses);
        end
        n_cmp++;
        if (last_tx_word[6 +: 512] !== c_beat[6 +: 512] ||
            last_tx_word[543 +: 512] !== d_beat[6 +: 512]) begin
            n_err++;
            $display("FAIL pair_data: got lo %h hi %h expected lo %h hi %h",
                     last_tx_word[6 +: 64], last_tx_word[543 +: 64], c_beat[6 +: 64], d_beat[6 +: 64]);
        end
    endtask

    task automatic test_tx_stall();
        logic [536:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = rand_beat(1);
        tx_ready = 0;
        for (int i = 0; i < 4; i++) begin
            u_beat = b[i];
            tick();
        end
        u_beat = '0;
        repeat (3) tick();
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== {b[1], b[0]}) begin
            n_err++;
            $display("FAIL stall_held: got valid %b word_lo %h expected valid 1 word_lo %h",
                     tx_valid, tx_data[63:0], b[0][63:0]);
        end
        n_cmp++;
        if (tx_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL stall_overflow: got %b expected 1", tx_ovf);
        end
        tx_ready = 1;
        repeat (3) tick();
        n_cmp++;
        if (tx_ovf !== 1'b1 || tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_sticky: got ovf %b valid %b expected 1 0", tx_ovf, tx_valid);
        end
    endtask

    task automatic test_reset_mid();
        tx_ready = 0;
        rx_valid = 1;
        rx_data  = {rand_beat(1), rand_beat(1)};
        tick();
        rx_data  = {rand_beat(1), rand_beat(1)};
        u_beat   = rand_beat(1);
        tick();
        idle_inputs();
        #3;
        rst_wr_n = 0;
        #1;
        model_reset();
        n_cmp++;
        if (dstrm_now() !== '0 || tx_data !== '0 || tx_valid !== 0 || tx_ovf !== 0) begin
            n_err++;
            $display("FAIL midreset_async: dstrm_valid=%b tx_valid=%b tx_ovf=%b expected all zero",
                     d_valid, tx_valid, tx_ovf);
        end
        @(posedge clk_wr);
        #1;
        rst_wr_n = 1;
        #1;
        n_cmp++;
        if (rx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_ready: got %b expected 1", rx_ready);
        end
        // Idle ticks: any leftover beat would show up against the empty model.
        repeat (3) tick();
        tx_ready = 1;
        test_rx_single();
    endtask

    task automatic test_back_to_back();
        tx_ready  = 1;
        tx_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            u_beat = rand_beat(1);
            tick();
        end
        u_beat = '0;
        tick();
        n_cmp++;
        if (tx_pulses != 4 || tx_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL b2b: got pulses %0d ovf %b expected 4 0", tx_pulses, tx_ovf);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rx_valid = ($urandom_range(0, 3) != 0);
            rx_data  = {rand_beat($urandom_range(0, 1) == 1), rand_beat(1)};
            u_beat   = rand_beat($urandom_range(0, 2) != 0);
            tx_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        idle_inputs();
        tx_ready = 1;
        repeat (8) tick();
    endtask

    initial begin
        test_reset();
        test_rx_single();
        test_rx_stream();
        test_tx_pair();
        test_tx_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
